score_keeper: RTL

Judges player button presses against arrow notes and maintains the running game score consumed by the two-digit score display. Sits between the note sequencer, which emits a pulse when an arrow reaches the target line, and the score display stage. It drives the 9-bit `score` bus directly. Score saturates at 99 because the display shows only two decimal digits.

---
 rtl/ddr_pkg.sv | 41 ++++
 rtl/button_edge.sv | 38 +++
 rtl/score_keeper.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg
//
// Shared definitions for the arrow-game judging logic: lane count, bus widths
// for the score and combo counters, the judge FSM state type and a small
// saturating helper used when a hit is scored.
//
// Contents:
//   NUM_LANES          number of arrow lanes / buttons
//   SCORE_W            width of the score bus driven to the display stage
//   COMBO_W            width of the combo counter
//   DEFAULT_MAX_SCORE  default score ceiling (two decimal digits on display)
//   MAX_COMBO          combo ceiling
//   judge_state_t      IDLE (no note pending) / WINDOW (note being judged)
//   clamp_score()      clamps a one-bit-wider sum to a ceiling
// ---------------------------------------------------------------------------
package ddr_pkg;

  localparam int NUM_LANES         = 4;
  localparam int SCORE_W           = 9;
  localparam int COMBO_W           = 7;
  localparam int DEFAULT_MAX_SCORE = 99;
  localparam int MAX_COMBO         = 99;

  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } judge_state_t;

  // The sum is carried one bit wider than the score so that an increment on
  // a score already near the top of its range cannot wrap before clamping.
  function automatic logic [SCORE_W-1:0] clamp_score(
    input logic [SCORE_W:0] sum,
    input logic [SCORE_W:0] ceiling
  );
    logic [SCORE_W:0] limited;
    limited = (sum > ceiling) ? ceiling : sum;
    return limited[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/button_edge.sv
// ---------------------------------------------------------------------------
// button_edge
//
// Rising-edge detector for the lane buttons. The previous-sample register
// comes out of reset with every lane marked as already pressed, so a button
// that is held down across reset never produces a press.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   buttons  lane buttons, already synchronized to clk
//   rise     one bit per lane, high in the cycle a button goes 0 -> 1
// ---------------------------------------------------------------------------
module button_edge
  import ddr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] buttons,
  output logic [NUM_LANES-1:0] rise
);

  logic [NUM_LANES-1:0] prev_buttons;

  // Remember last cycle's button levels. Reset loads all ones so held
  // buttons look "already down" and only a genuine release/press counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_buttons <= '1;
    end else begin
      prev_buttons <= buttons;
    end
  end

  // A press is seen in the same cycle the button level first goes high.
  assign rise = buttons & ~prev_buttons;

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//
// Judges player button presses against arrow notes coming from the note
// sequencer and keeps the running score and combo shown on the two-digit
// score display.
//
// A note opens a hit window. While the window is open every lane press is
// collected; pressing a lane the note does not use is an immediate miss,
// collecting every required lane is a hit, and running out the window is a
// miss. Hits add 1 (or 2 once the combo has reached the bonus threshold) to
// a score that saturates at MAX_SCORE; misses clear the combo.
//
// Parameters:
//   WINDOW_CYCLES   hit-window length in clk cycles, counted from acceptance
//   MAX_SCORE       saturation ceiling for score
//   COMBO_BONUS_AT  combo value at or above which a hit scores +2
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   clear        synchronous pulse: zero score and combo, abandon any note
//   game_active  level; when low no notes are accepted and nothing updates
//   buttons      lane buttons, active-high, synchronized to clk
//   note_valid   one-cycle pulse from the sequencer
//   note_lanes   lanes required by the note, sampled with note_valid
//   score        registered score, 0..MAX_SCORE
//   combo        registered consecutive-hit count, saturating at 99
//   hit_pulse    one-cycle strobe in the cycle a hit becomes visible
//   miss_pulse   one-cycle strobe in the cycle combo clears on a miss
// ---------------------------------------------------------------------------
module score_keeper
  import ddr_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = 1_000_000,
  parameter int unsigned MAX_SCORE      = DEFAULT_MAX_SCORE,
  parameter int unsigned COMBO_BONUS_AT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 game_active,
  input  logic [NUM_LANES-1:0] buttons,
  input  logic                 note_valid,
  input  logic [NUM_LANES-1:0] note_lanes,
  output logic [SCORE_W-1:0]   score,
  output logic [COMBO_W-1:0]   combo,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  // A one-cycle window still needs a one-bit counter to hold its single
  // count value.
  localparam int CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [SCORE_W:0]   SCORE_CEIL = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [COMBO_W-1:0] COMBO_CEIL = COMBO_W'(MAX_COMBO);
  localparam logic [COMBO_W-1:0] BONUS_AT   = COMBO_W'(COMBO_BONUS_AT);

  judge_state_t         state, state_n;
  logic [NUM_LANES-1:0] lanes, lanes_n;
  logic [NUM_LANES-1:0] pressed, pressed_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [SCORE_W-1:0]   score_n;
  logic [COMBO_W-1:0]   combo_n;
  logic                 hit_n, miss_n;

  logic [NUM_LANES-1:0] rise;
  logic [NUM_LANES-1:0] pressed_acc;
  logic                 wrong, done, tmo, accept;
  logic [SCORE_W:0]     inc, score_sum;
  logic [SCORE_W-1:0]   score_hit;
  logic [COMBO_W-1:0]   combo_hit;

  button_edge u_button_edge (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .rise    (rise)
  );

  // Per-cycle judging terms for the open window. pressed_acc is the set of
  // required lanes seen so far including this cycle's presses, so a note is
  // completed in the very cycle its last lane goes down.
  always_comb begin
    pressed_acc = pressed | rise;
    wrong       = |(rise & ~lanes);
    done        = (pressed_acc == lanes);
    tmo         = (cnt == CNT_LAST);
    accept      = note_valid && (note_lanes != '0);
  end

  // Values a hit would produce. The bonus is chosen from the combo before
  // this hit, and the score sum is formed one bit wide before clamping.
  always_comb begin
    inc       = (combo >= BONUS_AT) ? (SCORE_W + 1)'(2) : (SCORE_W + 1)'(1);
    score_sum = {1'b0, score} + inc;
    score_hit = clamp_score(score_sum, SCORE_CEIL);
    combo_hit = (combo >= COMBO_CEIL) ? COMBO_CEIL : combo + 1'b1;
  end

  // Next-state logic. Priority: clear, then game_active low, then the FSM.
  // In WINDOW the current note is always resolved before a newly arriving
  // note is loaded, so a note arriving mid-window produces exactly one pulse
  // for the old note (a still-pending old note counts as a miss) and the
  // new note then opens a fresh window.
  always_comb begin
    state_n   = state;
    lanes_n   = lanes;
    pressed_n = pressed;
    cnt_n     = cnt;
    score_n   = score;
    combo_n   = combo;
    hit_n     = 1'b0;
    miss_n    = 1'b0;

    if (clear) begin
      state_n = IDLE;
      score_n = '0;
      combo_n = '0;
    end else if (!game_active) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_n   = WINDOW;
            lanes_n   = note_lanes;
            pressed_n = '0;
            cnt_n     = '0;
          end
        end

        WINDOW: begin
          if (wrong) begin
            combo_n = '0;
            miss_n  = 1'b1;
            state_n = IDLE;
          end else if (done) begin
            score_n = score_hit;
            combo_n = combo_hit;
            hit_n   = 1'b1;
            state_n = IDLE;
          end else if (tmo || note_valid) begin
            combo_n = '0;
            miss_n  = 1'b1;
            state_n = IDLE;
          end else begin
            pressed_n = pressed_acc;
            cnt_n     = cnt + 1'b1;
          end

          if (accept) begin
            state_n   = WINDOW;
            lanes_n   = note_lanes;
            pressed_n = '0;
            cnt_n     = '0;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and output registers. Everything the display and sequencer see
  // is registered, so pulses line up with the score/combo change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lanes      <= '0;
      pressed    <= '0;
      cnt        <= '0;
      score      <= '0;
      combo      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      lanes      <= lanes_n;
      pressed    <= pressed_n;
      cnt        <= cnt_n;
      score      <= score_n;
      combo      <= combo_n;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
    end
  end

endmodule
